// File: rtl/collide_pkg.sv
// Shared encodings for the boundary-table collision scanner.
package collide_pkg;

    localparam int CW_DEF    = 10;
    localparam int DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        SIDE_T = 2'd0,
        SIDE_B = 2'd1,
        SIDE_L = 2'd2,
        SIDE_R = 2'd3
    } side_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/collide_edge_table.sv
// One side's boundary table: register storage, write port, indexed read and
// the contact comparator for that side.
module collide_edge_table
    import collide_pkg::*;
#(
    parameter int    CW    = CW_DEF,
    parameter int    DEPTH = DEPTH_DEF,
    parameter int    IW    = $clog2(DEPTH),
    parameter side_e SIDE  = SIDE_T
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic          wr_valid,
    input  logic [CW-1:0] wr_lo,
    input  logic [CW-1:0] wr_hi,
    input  logic [CW-1:0] wr_pos,
    input  logic [IW-1:0] rd_idx,
    input  logic [CW-1:0] kid_t,
    input  logic [CW-1:0] kid_b,
    input  logic [CW-1:0] kid_l,
    input  logic [CW-1:0] kid_r,
    output logic          hit
);

    typedef struct packed {
        logic          valid;
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;
        logic [CW-1:0] pos;
    } edge_t;

    logic [DEPTH-1:0] valid_q;
    logic [CW-1:0]    lo_q  [DEPTH];
    logic [CW-1:0]    hi_q  [DEPTH];
    logic [CW-1:0]    pos_q [DEPTH];

    edge_t         ent;
    logic          wr_ok;
    logic [CW-1:0] coord, near, far;

    // Out-of-range indices only exist for non-power-of-2 depths; drop them.
    assign wr_ok = wr_en && (32'(wr_idx) < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid_q <= '0;
        else if (wr_ok)
            valid_q[wr_idx] <= wr_valid;
    end

    // Payload needs no reset: an entry is ignored until its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            lo_q[wr_idx]  <= wr_lo;
            hi_q[wr_idx]  <= wr_hi;
            pos_q[wr_idx] <= wr_pos;
        end
    end

    assign ent = '{valid: valid_q[rd_idx], lo: lo_q[rd_idx],
                   hi: hi_q[rd_idx], pos: pos_q[rd_idx]};

    // T/B edges span x (kid l..r); L/R edges span y (kid t..b).
    always_comb begin
        coord = kid_t;
        near  = kid_l;
        far   = kid_r;
        case (SIDE)
            SIDE_T: begin coord = kid_t; near = kid_l; far = kid_r; end
            SIDE_B: begin coord = kid_b; near = kid_l; far = kid_r; end
            SIDE_L: begin coord = kid_l; near = kid_t; far = kid_b; end
            SIDE_R: begin coord = kid_r; near = kid_t; far = kid_b; end
            default: ;
        endcase
    end

    assign hit = ent.valid && (coord == ent.pos) && (near < ent.hi) && (far > ent.lo);

endmodule

// File: rtl/collide_scan.sv
// Runtime-loadable kid collision scanner: four side tables walked one index
// per clock after a start pulse, reporting {T,B,L,R} contact.
module collide_scan
    import collide_pkg::*;
#(
    parameter  int CW    = CW_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_side,
    input  logic [IW-1:0] wr_idx,
    input  logic          wr_valid,
    input  logic [CW-1:0] wr_lo,
    input  logic [CW-1:0] wr_hi,
    input  logic [CW-1:0] wr_pos,
    input  logic          start,
    input  logic [CW-1:0] kid_t,
    input  logic [CW-1:0] kid_b,
    input  logic [CW-1:0] kid_l,
    input  logic [CW-1:0] kid_r,
    output logic          busy,
    output logic          done,
    output logic [3:0]    is_collide
);

    typedef struct packed {
        logic [CW-1:0] t;
        logic [CW-1:0] b;
        logic [CW-1:0] l;
        logic [CW-1:0] r;
    } kid_box_t;

    state_e        state, state_d;
    logic [IW-1:0] idx;
    kid_box_t      kid_q;
    logic [3:0]    acc;
    logic [3:0]    hits;
    logic          wr_go;
    logic          last;

    assign busy  = (state != ST_IDLE);
    assign wr_go = wr_en && (state == ST_IDLE);
    assign last  = (idx == IW'(DEPTH - 1));

    for (genvar g = 0; g < 4; g++) begin : g_side
        collide_edge_table #(
            .CW    (CW),
            .DEPTH (DEPTH),
            .IW    (IW),
            .SIDE  (side_e'(g))
        ) u_tbl (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_go && (wr_side == 2'(g))),
            .wr_idx   (wr_idx),
            .wr_valid (wr_valid),
            .wr_lo    (wr_lo),
            .wr_hi    (wr_hi),
            .wr_pos   (wr_pos),
            .rd_idx   (idx),
            .kid_t    (kid_q.t),
            .kid_b    (kid_q.b),
            .kid_l    (kid_q.l),
            .kid_r    (kid_q.r),
            .hit      (hits[3-g])
        );
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: if (last)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            kid_q      <= '0;
            acc        <= '0;
            done       <= 1'b0;
            is_collide <= '0;
        end else begin
            state <= state_d;
            done  <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    kid_q <= '{t: kid_t, b: kid_b, l: kid_l, r: kid_r};
                    idx   <= '0;
                    acc   <= '0;
                end
                ST_SCAN: begin
                    acc <= acc | hits;
                    if (!last) idx <= idx + IW'(1);
                end
                ST_DONE: begin
                    done       <= 1'b1;
                    is_collide <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collide_scan.sv
// Directed bench for collide_scan with an expected-result queue popped on done.
module tb_collide_scan;

    localparam int CW    = 10;
    localparam int DEPTH = 16;
    localparam int IW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [1:0]    wr_side;
    logic [IW-1:0] wr_idx;
    logic          wr_valid;
    logic [CW-1:0] wr_lo, wr_hi, wr_pos;
    logic          start;
    logic [CW-1:0] kid_t, kid_b, kid_l, kid_r;
    logic          busy, done;
    logic [3:0]    is_collide;

    int         vectors = 0;
    int         miscompares = 0;
    int         done_cnt = 0;
    int         cyc_cnt = 0;
    int         scan_t0 = 0;
    int         d_snap;
    logic [3:0] exp_q[$];

    collide_scan #(.CW(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_side(wr_side), .wr_idx(wr_idx),
        .wr_valid(wr_valid), .wr_lo(wr_lo), .wr_hi(wr_hi), .wr_pos(wr_pos),
        .start(start), .kid_t(kid_t), .kid_b(kid_b), .kid_l(kid_l), .kid_r(kid_r),
        .busy(busy), .done(done), .is_collide(is_collide)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input logic [1:0] side, input logic [IW-1:0] idx, input logic v,
                               input logic [CW-1:0] lo, input logic [CW-1:0] hi,
                               input logic [CW-1:0] pos);
        @(negedge clk);
        wr_side = side; wr_idx = idx; wr_valid = v; wr_lo = lo; wr_hi = hi; wr_pos = pos;
        wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Caller aligns to a negedge first; any wr_en set by the caller lands on the same edge.
    task automatic start_scan(input logic [CW-1:0] t, input logic [CW-1:0] b,
                              input logic [CW-1:0] l, input logic [CW-1:0] r,
                              input logic [3:0] exp);
        kid_t = t; kid_b = b; kid_l = l; kid_r = r;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        scan_t0 = cyc_cnt;
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic [3:0] e;
        while (done !== 1'b1 && (cyc_cnt - scan_t0) < 200) begin
            @(posedge clk); #1;
        end
        check({tag, "_latency"}, cyc_cnt - scan_t0, DEPTH + 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
        check({tag, "_collide"}, is_collide, e);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    task automatic run_scan(input string tag, input logic [CW-1:0] t, input logic [CW-1:0] b,
                            input logic [CW-1:0] l, input logic [CW-1:0] r,
                            input logic [3:0] exp);
        @(negedge clk);
        start_scan(t, b, l, r, exp);
        wait_done(tag);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_side = '0; wr_idx = '0; wr_valid = 1'b0;
        wr_lo = '0; wr_hi = '0; wr_pos = '0; start = 1'b0;
        kid_t = '0; kid_b = '0; kid_l = '0; kid_r = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_collide", is_collide, 4'b0000);
        rst = 1'b0;

        // Empty tables
        run_scan("empty", 10'd0, 10'd0, 10'd0, 10'd0, 4'b0000);

        // Top edge contact
        write_entry(2'd0, 4'd0, 1'b1, 10'd60, 10'd125, 10'd416);
        run_scan("top_hit", 10'd416, 10'd448, 10'd70, 10'd100, 4'b1000);

        // Touching corner only: strict inequality rejects it
        run_scan("corner", 10'd416, 10'd448, 10'd125, 10'd157, 4'b0000);

        // Bottom edge in the last index
        write_entry(2'd1, 4'(DEPTH - 1), 1'b1, 10'd28, 10'd677, 10'd578);
        run_scan("bot_last", 10'd546, 10'd578, 10'd40, 10'd72, 4'b0100);

        // Right edge preloaded, left edge written in the same cycle as start
        write_entry(2'd3, 4'd7, 1'b1, 10'd100, 10'd200, 10'd300);
        @(negedge clk);
        wr_side = 2'd2; wr_idx = 4'd2; wr_valid = 1'b1;
        wr_lo = 10'd100; wr_hi = 10'd200; wr_pos = 10'd270; wr_en = 1'b1;
        start_scan(10'd150, 10'd180, 10'd270, 10'd300, 4'b0011);
        wait_done("lr_same_cycle");

        // Mid-scan kid change, write and start are all ignored
        d_snap = done_cnt;
        @(negedge clk);
        start_scan(10'd416, 10'd448, 10'd70, 10'd100, 4'b1000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        kid_t = 10'd0; kid_b = 10'd0; kid_l = 10'd0; kid_r = 10'd0;
        wr_side = 2'd0; wr_idx = 4'd0; wr_valid = 1'b0; wr_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        check("mid_busy", busy, 1'b1);
        wait_done("mid_scan");
        repeat (DEPTH + 4) @(posedge clk);
        #1 check("mid_one_done", done_cnt - d_snap, 1);
        check("mid_idle", busy, 1'b0);
        run_scan("table_kept", 10'd416, 10'd448, 10'd70, 10'd100, 4'b1000);

        // Reset in the middle of a scan
        d_snap = done_cnt;
        @(negedge clk);
        start_scan(10'd416, 10'd448, 10'd70, 10'd100, 4'b1000);
        exp_q.delete();
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_collide", is_collide, 4'b0000);
        check("rstmid_done", done, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (DEPTH + 4) @(posedge clk);
        #1 check("rstmid_no_done", done_cnt - d_snap, 0);
        run_scan("cleared_top", 10'd416, 10'd448, 10'd70, 10'd100, 4'b0000);
        run_scan("cleared_lr", 10'd150, 10'd180, 10'd270, 10'd300, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
